// File: rtl/mul_16_16_sched.sv
// mul_16_16_sched: round-robin two-requester front end for the shared wallace_16_16 multiplier.
// Defining MUL_SCHED_PERF_EN adds the perf_clr/perf_ops/perf_stall counters.

module mul_16_16_sched #(
   parameter int TAG_W = 4
`ifdef MUL_SCHED_PERF_EN
   ,parameter int PERF_W = 32
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [15:0]      req0_a,
   input  logic [15:0]      req0_b,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [15:0]      req1_a,
   input  logic [15:0]      req1_b,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [31:0]      booth_in0,
   output logic [31:0]      booth_in1,
   output logic [31:0]      booth_in2,
   output logic [31:0]      booth_in3,
   output logic [31:0]      booth_in4,
   output logic [31:0]      booth_in5,
   output logic [31:0]      booth_in6,
   output logic [31:0]      booth_in7,
   input  logic [31:0]      add_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_product,
   output logic             rsp_src,
   output logic [TAG_W-1:0] rsp_tag
`ifdef MUL_SCHED_PERF_EN
   ,input  logic              perf_clr
   ,output logic [PERF_W-1:0] perf_ops
   ,output logic [PERF_W-1:0] perf_stall
`endif
);

   typedef enum logic {
      PREF_REQ0 = 1'b0,
      PREF_REQ1 = 1'b1
   } ptr_e;

   ptr_e              r_ptr;
   logic              r_s1Valid;
   logic [7:0][31:0]  r_booth;
   logic              r_s1Src;
   logic [TAG_W-1:0]  r_s1Tag;
   logic              r_rspValid;
   logic [31:0]       r_rspProduct;
   logic              r_rspSrc;
   logic [TAG_W-1:0]  r_rspTag;

   logic              w_s2Free;
   logic              w_accept;
   logic              w_anyValid;
   logic              w_grant0;
   logic              w_grant1;
   logic [15:0]       w_selA;
   logic [15:0]       w_selB;
   logic [TAG_W-1:0]  w_selTag;
   logic [16:0]       w_bExt;
   logic [31:0]       w_aExt;
   logic [7:0][31:0]  w_pp;

   // Readies are forced low while reset is asserted so nothing appears accepted.
   assign w_s2Free   = !r_rspValid | rsp_ready;
   assign w_accept   = rst_n & (!r_s1Valid | w_s2Free);
   assign w_anyValid = req0_valid | req1_valid;
   assign w_grant0   = req0_valid & (!req1_valid | (r_ptr == PREF_REQ0));
   assign w_grant1   = req1_valid & (!req0_valid | (r_ptr == PREF_REQ1));
   assign req0_ready = w_accept & w_grant0;
   assign req1_ready = w_accept & w_grant1;

   assign w_selA   = w_grant1 ? req1_a   : req0_a;
   assign w_selB   = w_grant1 ? req1_b   : req0_b;
   assign w_selTag = w_grant1 ? req1_tag : req0_tag;

   // Radix-4 Booth rows, each fully negated in two's complement so no correction row is needed.
   always_comb begin
      logic [31:0] v;
      w_bExt = {w_selB, 1'b0};
      w_aExt = {{16{w_selA[15]}}, w_selA};
      w_pp   = '0;
      for (int i = 0; i < 8; i++) begin
         case (w_bExt[2*i +: 3])
            3'b001, 3'b010: v = w_aExt;
            3'b011:         v = w_aExt << 1;
            3'b100:         v = ~(w_aExt << 1) + 32'd1;
            3'b101, 3'b110: v = ~w_aExt + 32'd1;
            default:        v = '0;
         endcase
         w_pp[i] = v << (2*i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid <= 1'b0;
         r_booth   <= '0;
         r_s1Src   <= 1'b0;
         r_s1Tag   <= '0;
         r_ptr     <= PREF_REQ0;
      end else if (w_accept) begin
         r_s1Valid <= w_anyValid;
         if (w_anyValid) begin
            r_booth <= w_pp;
            r_s1Src <= w_grant1;
            r_s1Tag <= w_selTag;
            r_ptr   <= w_grant0 ? PREF_REQ1 : PREF_REQ0;
         end
      end
   end

   // S2 only moves when free, so a stalled response keeps every field stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rspValid   <= 1'b0;
         r_rspProduct <= '0;
         r_rspSrc     <= 1'b0;
         r_rspTag     <= '0;
      end else if (w_s2Free) begin
         r_rspValid <= r_s1Valid;
         if (r_s1Valid) begin
            r_rspProduct <= add_out;
            r_rspSrc     <= r_s1Src;
            r_rspTag     <= r_s1Tag;
         end
      end
   end

   assign booth_in0   = r_booth[0];
   assign booth_in1   = r_booth[1];
   assign booth_in2   = r_booth[2];
   assign booth_in3   = r_booth[3];
   assign booth_in4   = r_booth[4];
   assign booth_in5   = r_booth[5];
   assign booth_in6   = r_booth[6];
   assign booth_in7   = r_booth[7];
   assign rsp_valid   = r_rspValid;
   assign rsp_product = r_rspProduct;
   assign rsp_src     = r_rspSrc;
   assign rsp_tag     = r_rspTag;

`ifdef MUL_SCHED_PERF_EN
   logic [PERF_W-1:0] r_perfOps;
   logic [PERF_W-1:0] r_perfStall;

   // Saturating counters; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perfOps   <= '0;
         r_perfStall <= '0;
      end else if (perf_clr) begin
         r_perfOps   <= '0;
         r_perfStall <= '0;
      end else begin
         if (r_rspValid && rsp_ready && !(&r_perfOps))
            r_perfOps <= r_perfOps + PERF_W'(1);
         if (r_rspValid && !rsp_ready && !(&r_perfStall))
            r_perfStall <= r_perfStall + PERF_W'(1);
      end
   end

   assign perf_ops   = r_perfOps;
   assign perf_stall = r_perfStall;
`endif

endmodule

// File: tb/tb_mul_16_16_sched.sv
// tb_mul_16_16_sched: scoreboard bench for mul_16_16_sched with a behavioural wallace_16_16 adder.
// Perf-counter scenario is built only when MUL_SCHED_PERF_EN is defined.

module tb_mul_16_16_sched;

   localparam int TAG_W = 4;

   typedef struct packed {
      logic [31:0]      prod;
      logic             src;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0]      req0_a, req0_b, req1_a, req1_b;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic [31:0]      booth_in0, booth_in1, booth_in2, booth_in3;
   logic [31:0]      booth_in4, booth_in5, booth_in6, booth_in7;
   logic [31:0]      add_out;
   logic             rsp_valid, rsp_ready, rsp_src;
   logic [31:0]      rsp_product;
   logic [TAG_W-1:0] rsp_tag;
`ifdef MUL_SCHED_PERF_EN
   logic             perf_clr = 1'b0;
   logic [31:0]      perf_ops, perf_stall;
`endif

   exp_t             sbq[$];
   int               checks = 0;
   int               failures = 0;
   logic             obsAcc0, obsAcc1, obsRspV, obsFire, obsSrc;
   logic [31:0]      obsProd;
   logic [TAG_W-1:0] obsTag;

   always #5 clk = ~clk;

   // Reference wallace_16_16: plain modular sum of the eight rows.
   assign add_out = booth_in0 + booth_in1 + booth_in2 + booth_in3
                  + booth_in4 + booth_in5 + booth_in6 + booth_in7;

   mul_16_16_sched #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
      .booth_in0(booth_in0), .booth_in1(booth_in1), .booth_in2(booth_in2), .booth_in3(booth_in3),
      .booth_in4(booth_in4), .booth_in5(booth_in5), .booth_in6(booth_in6), .booth_in7(booth_in7),
      .add_out(add_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
      .rsp_src(rsp_src), .rsp_tag(rsp_tag)
`ifdef MUL_SCHED_PERF_EN
      ,.perf_clr(perf_clr), .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
   );

   function automatic logic [31:0] refMul(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] ea, eb;
      ea = $signed(a);
      eb = $signed(b);
      return ea * eb;
   endfunction

   function automatic logic [15:0] randOp();
      logic [15:0] corners [5];
      corners = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001};
      if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
      return 16'($urandom);
   endfunction

   // Stimulus changes at negedge; ready/rsp are sampled mid-cycle and accepted requests are scored.
   task automatic applyStimulus();
      #1;
      obsAcc0 = req0_valid & req0_ready;
      obsAcc1 = req1_valid & req1_ready;
      obsRspV = rsp_valid;
      obsFire = rsp_valid & rsp_ready;
      obsProd = rsp_product;
      obsSrc  = rsp_src;
      obsTag  = rsp_tag;
      if (obsAcc0) sbq.push_back(exp_t'{prod: refMul(req0_a, req0_b), src: 1'b0, tag: req0_tag});
      if (obsAcc1) sbq.push_back(exp_t'{prod: refMul(req1_a, req1_b), src: 1'b1, tag: req1_tag});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic setIdle();
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_tag = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_tag = '0;
   endtask

   task automatic test_reset();
      req0_valid = 1'b1;
      #1;
      checks += 6;
      if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
      if (rsp_product !== 32'h0) begin failures++; $display("[TB] FAIL reset_rsp_product got %h expected 0", rsp_product); end
      if (rsp_src !== 1'b0 || rsp_tag !== '0) begin failures++; $display("[TB] FAIL reset_rsp_id got src=%b tag=%h expected 0", rsp_src, rsp_tag); end
      if (booth_in0 !== 32'h0) begin failures++; $display("[TB] FAIL reset_booth0 got %h expected 0", booth_in0); end
      if (booth_in7 !== 32'h0) begin failures++; $display("[TB] FAIL reset_booth7 got %h expected 0", booth_in7); end
      if (req0_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got %b expected 0", req0_ready); end
      @(negedge clk);
      req0_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      exp_t e;
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 16'hFFFD; req0_b = 16'd5; req0_tag = 4'd2;
      applyStimulus();
      checks++;
      if (obsAcc0 !== 1'b1) begin failures++; $display("[TB] FAIL basic_accept got %b expected 1", obsAcc0); end
      setIdle();
      applyStimulus();
      checks++;
      if (obsRspV !== 1'b0) begin failures++; $display("[TB] FAIL basic_latency_early got rsp_valid=%b expected 0", obsRspV); end
      applyStimulus();
      checks++;
      if (obsFire !== 1'b1 || obsProd !== 32'hFFFF_FFF1 || obsSrc !== 1'b0 || obsTag !== 4'd2) begin
         failures++;
         $display("[TB] FAIL basic_rsp got fire=%b prod=%h src=%b tag=%0d expected fire=1 prod=fffffff1 src=0 tag=2",
                  obsFire, obsProd, obsSrc, obsTag);
      end
      if (obsFire) begin
         checks++;
         if (sbq.size() == 0) begin failures++; $display("[TB] FAIL basic_sb got rsp %h expected no rsp", obsProd); end
         else begin
            e = sbq.pop_front();
            if ({obsProd, obsSrc, obsTag} !== e) begin failures++; $display("[TB] FAIL basic_sb got %h/%b/%0d expected %h/%b/%0d", obsProd, obsSrc, obsTag, e.prod, e.src, e.tag); end
         end
      end
   endtask

   task automatic test_corner();
      logic [31:0] expProd [2];
      int got = 0;
      expProd = '{32'h4000_0000, 32'hC000_8000};
      rsp_ready = 1'b1;
      req1_valid = 1'b1; req1_a = 16'h8000; req1_b = 16'h8000; req1_tag = 4'd5;
      applyStimulus();
      req1_a = 16'h7FFF; req1_b = 16'h8000; req1_tag = 4'd6;
      applyStimulus();
      setIdle();
      for (int c = 0; c < 6; c++) begin
         if (obsFire && got < 2) begin
            checks++;
            if (obsProd !== expProd[got] || obsSrc !== 1'b1 || obsTag !== 4'(5 + got)) begin
               failures++;
               $display("[TB] FAIL corner_%0d got prod=%h src=%b tag=%0d expected prod=%h src=1 tag=%0d",
                        got, obsProd, obsSrc, obsTag, expProd[got], 5 + got);
            end
            got++;
         end
         applyStimulus();
      end
      checks++;
      if (got != 2) begin failures++; $display("[TB] FAIL corner_count got %0d rsps expected 2", got); end
      sbq.delete();
   endtask

   task automatic test_round_robin();
      exp_t e;
      int fires = 0, firstFire = -1, lastFire = -1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c < 4) begin
            req0_valid = 1'b1; req0_a = randOp(); req0_b = randOp(); req0_tag = 4'(c);
            req1_valid = 1'b1; req1_a = randOp(); req1_b = randOp(); req1_tag = 4'(8 + c);
         end else setIdle();
         applyStimulus();
         if (c < 4) begin
            checks++;
            if (obsAcc0 !== (c % 2 == 0) || obsAcc1 !== (c % 2 == 1)) begin
               failures++;
               $display("[TB] FAIL rr_grant_%0d got g0=%b g1=%b expected g0=%b g1=%b", c, obsAcc0, obsAcc1, c % 2 == 0, c % 2 == 1);
            end
         end
         if (obsFire) begin
            if (firstFire < 0) firstFire = c;
            lastFire = c;
            fires++;
            checks++;
            if (sbq.size() == 0) begin failures++; $display("[TB] FAIL rr_sb got rsp %h expected no rsp", obsProd); end
            else begin
               e = sbq.pop_front();
               if ({obsProd, obsSrc, obsTag} !== e) begin failures++; $display("[TB] FAIL rr_sb got %h/%b/%0d expected %h/%b/%0d", obsProd, obsSrc, obsTag, e.prod, e.src, e.tag); end
            end
         end
      end
      checks++;
      if (fires != 4 || firstFire != 2 || lastFire != 5) begin
         failures++;
         $display("[TB] FAIL rr_back_to_back got %0d rsps cycles %0d..%0d expected 4 rsps cycles 2..5", fires, firstFire, lastFire);
      end
   endtask

   task automatic test_back_to_back_stall();
      exp_t e;
      int sent = 0, got = 0;
      for (int c = 0; c < 12; c++) begin
         rsp_ready = (c >= 5);
         req0_valid = (sent < 3);
         req0_a = randOp(); req0_b = randOp(); req0_tag = 4'(sent);
         if (c == 2) begin checks++; if (sbq.size() != 2) begin failures++; $display("[TB] FAIL stall_queue got %0d expected 2", sbq.size()); end end
         applyStimulus();
         if (obsAcc0) sent++;
         if (c < 2) begin
            checks++;
            if (obsAcc0 !== 1'b1) begin failures++; $display("[TB] FAIL stall_accept_%0d got %b expected 1", c, obsAcc0); end
         end else if (c < 5) begin
            checks += 2;
            if (obsAcc0 !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready_%0d got %b expected 0", c, obsAcc0); end
            if (obsRspV !== 1'b1 || sbq.size() == 0 || {obsProd, obsSrc, obsTag} !== sbq[0]) begin
               failures++;
               $display("[TB] FAIL stall_hold_%0d got valid=%b %h/%b/%0d expected held head of queue", c, obsRspV, obsProd, obsSrc, obsTag);
            end
         end
         if (obsFire) begin
            got++;
            checks++;
            if (sbq.size() == 0) begin failures++; $display("[TB] FAIL stall_sb got rsp %h expected no rsp", obsProd); end
            else begin
               e = sbq.pop_front();
               if ({obsProd, obsSrc, obsTag} !== e) begin failures++; $display("[TB] FAIL stall_sb got %h/%b/%0d expected %h/%b/%0d", obsProd, obsSrc, obsTag, e.prod, e.src, e.tag); end
            end
         end
      end
      setIdle();
      checks++;
      if (got != 3 || sbq.size() != 0) begin failures++; $display("[TB] FAIL stall_count got %0d rsps, %0d left expected 3 rsps, 0 left", got, sbq.size()); end
   endtask

   task automatic test_reset_midop();
      exp_t e;
      int got = 0;
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 16'd11; req0_b = 16'd13; req0_tag = 4'd1;
      applyStimulus();
      req0_a = 16'd17; req0_tag = 4'd2;
      applyStimulus();
      req1_valid = 1'b1; req1_a = 16'hFFF7; req1_b = 16'd7; req1_tag = 4'd9;
      rst_n = 1'b0;
      #1;
      checks += 2;
      if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_rsp_valid got %b expected 0", rsp_valid); end
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ready got %b%b expected 00", req0_ready, req1_ready); end
      @(negedge clk);
      sbq.delete();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      req0_a = 16'd100; req0_b = 16'hFFFE; req0_tag = 4'd4;
      applyStimulus();
      checks++;
      if (obsAcc0 !== 1'b1 || obsAcc1 !== 1'b0) begin failures++; $display("[TB] FAIL midreset_pointer got g0=%b g1=%b expected g0=1 g1=0", obsAcc0, obsAcc1); end
      setIdle();
      for (int c = 0; c < 5; c++) begin
         applyStimulus();
         if (obsFire) begin
            got++;
            checks++;
            if (sbq.size() == 0) begin failures++; $display("[TB] FAIL midreset_sb got rsp %h expected no rsp", obsProd); end
            else begin
               e = sbq.pop_front();
               if ({obsProd, obsSrc, obsTag} !== e) begin failures++; $display("[TB] FAIL midreset_sb got %h/%b/%0d expected %h/%b/%0d", obsProd, obsSrc, obsTag, e.prod, e.src, e.tag); end
            end
         end
      end
      checks++;
      if (got != 1) begin failures++; $display("[TB] FAIL midreset_count got %0d rsps expected 1", got); end
   endtask

`ifdef MUL_SCHED_PERF_EN
   task automatic test_perf();
      exp_t e;
      int sent = 0, got = 0;
      setIdle();
      rsp_ready = 1'b1;
      perf_clr = 1'b1;
      applyStimulus();
      perf_clr = 1'b0;
      for (int c = 0; c < 30 && got < 10; c++) begin
         rsp_ready = !(c >= 4 && c < 7);
         req0_valid = (sent < 10);
         req0_a = randOp(); req0_b = randOp(); req0_tag = 4'(sent);
         applyStimulus();
         if (obsAcc0) sent++;
         if (obsFire) begin
            got++;
            checks++;
            if (sbq.size() == 0) begin failures++; $display("[TB] FAIL perf_sb got rsp %h expected no rsp", obsProd); end
            else begin
               e = sbq.pop_front();
               if ({obsProd, obsSrc, obsTag} !== e) begin failures++; $display("[TB] FAIL perf_sb got %h/%b/%0d expected %h/%b/%0d", obsProd, obsSrc, obsTag, e.prod, e.src, e.tag); end
            end
         end
      end
      setIdle();
      checks += 2;
      if (perf_ops !== 32'd10) begin failures++; $display("[TB] FAIL perf_ops got %0d expected 10", perf_ops); end
      if (perf_stall !== 32'd3) begin failures++; $display("[TB] FAIL perf_stall got %0d expected 3", perf_stall); end
      perf_clr = 1'b1;
      applyStimulus();
      perf_clr = 1'b0;
      checks++;
      if (perf_ops !== 32'd0 || perf_stall !== 32'd0) begin failures++; $display("[TB] FAIL perf_clr got ops=%0d stall=%0d expected 0/0", perf_ops, perf_stall); end
   endtask
`endif

   task automatic test_random();
      exp_t e;
      int sent = 0;
      for (int c = 0; c < 40000 && sent < 10000; c++) begin
         req0_valid = ($urandom_range(0, 3) != 0); req0_a = randOp(); req0_b = randOp(); req0_tag = 4'($urandom);
         req1_valid = ($urandom_range(0, 3) != 0); req1_a = randOp(); req1_b = randOp(); req1_tag = 4'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         applyStimulus();
         if (obsAcc0 && obsAcc1) begin failures++; checks++; $display("[TB] FAIL random_dual_grant got both readies expected one"); end
         sent += int'(obsAcc0) + int'(obsAcc1);
         if (obsFire) begin
            checks++;
            if (sbq.size() == 0) begin failures++; $display("[TB] FAIL random_sb got rsp %h expected no rsp", obsProd); end
            else begin
               e = sbq.pop_front();
               if ({obsProd, obsSrc, obsTag} !== e) begin failures++; $display("[TB] FAIL random_sb got %h/%b/%0d expected %h/%b/%0d", obsProd, obsSrc, obsTag, e.prod, e.src, e.tag); end
            end
         end
      end
      setIdle();
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         applyStimulus();
         if (obsFire) begin
            checks++;
            if (sbq.size() == 0) begin failures++; $display("[TB] FAIL random_drain got rsp %h expected no rsp", obsProd); end
            else begin
               e = sbq.pop_front();
               if ({obsProd, obsSrc, obsTag} !== e) begin failures++; $display("[TB] FAIL random_drain got %h/%b/%0d expected %h/%b/%0d", obsProd, obsSrc, obsTag, e.prod, e.src, e.tag); end
            end
         end
      end
      checks += 2;
      if (sent < 10000) begin failures++; $display("[TB] FAIL random_ops got %0d ops expected 10000", sent); end
      if (sbq.size() != 0) begin failures++; $display("[TB] FAIL random_lost got %0d pending expected 0", sbq.size()); end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      setIdle();
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_corner();
      test_round_robin();
      test_back_to_back_stall();
      test_reset_midop();
`ifdef MUL_SCHED_PERF_EN
      test_perf();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
